// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encodings and opcodes shared by the Simple-CPU control sequencer
package ctrl_pkg;
    localparam logic [4:0] S_IDLE   = 5'b11111;
    localparam logic [4:0] S_FETCH  = 5'b10000;
    localparam logic [4:0] S_DECODE = 5'b00000;
    localparam logic [4:0] S_LOAD   = 5'b00001;
    localparam logic [4:0] S_MOV    = 5'b00010;
    localparam logic [4:0] S_ALU    = 5'b00011;
    localparam logic [4:0] S_WB     = 5'b00101;
    localparam logic [4:0] S_BRANCH = 5'b00110;
    localparam logic [4:0] S_HALT   = 5'b00111;
    localparam logic [4:0] S_ERR    = 5'b01111;
    localparam logic [2:0] OP_LOAD   = 3'd0;
    localparam logic [2:0] OP_MOV    = 3'd1;
    localparam logic [2:0] OP_ADD    = 3'd2;
    localparam logic [2:0] OP_XOR    = 3'd3;
    localparam logic [2:0] OP_OR     = 3'd4;
    localparam logic [2:0] OP_AND    = 3'd5;
    localparam logic [2:0] OP_BRANCH = 3'd6;
    localparam logic [2:0] OP_HALT   = 3'd7;
endpackage

// File: rtl/ctrl_seq.sv
// ctrl_seq: registered control sequencer driving the Simple-CPU datapath enables
// Ports: clk, rst (async active-low), start, code[2:0] (opcode, sampled in DECODE),
//        mem_ready; outputs state[4:0] plus strobes ir_ld, pc_inc, mem_rd, reg_we,
//        alu_en, pc_ld and status halted, err.
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int ALU_LAT = 3,
    parameter int MEM_TO  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] code,
    input  logic       mem_ready,
    output logic [4:0] state,
    output logic       ir_ld,
    output logic       pc_inc,
    output logic       mem_rd,
    output logic       reg_we,
    output logic       alu_en,
    output logic       pc_ld,
    output logic       halted,
    output logic       err
);
    // Counter value seen in the final cycle of each timed state.
    localparam logic [7:0] ALU_LAST = 8'(ALU_LAT - 1);
    localparam logic [7:0] MEM_LAST = 8'(MEM_TO - 1);

    logic [4:0] state_d;
    logic [7:0] cnt;
    logic       timed;

    assign timed = (state == S_ALU) || (state == S_LOAD);

    // The counter restarts on any state change and saturates rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= (state_d != state) ? '0 : (timed && cnt != 8'hff) ? cnt + 8'd1 : cnt;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        case (state)
            S_IDLE, S_HALT, S_ERR: state_d = start ? S_FETCH : state;
            S_FETCH:               state_d = S_DECODE;
            S_DECODE:              state_d = (code == OP_LOAD)   ? S_LOAD :
                                             (code == OP_MOV)    ? S_MOV :
                                             (code == OP_BRANCH) ? S_BRANCH :
                                             (code == OP_HALT)   ? S_HALT : S_ALU;
            // mem_ready takes priority over the timeout in the same cycle.
            S_LOAD:                state_d = mem_ready ? S_FETCH : (cnt >= MEM_LAST) ? S_ERR : S_LOAD;
            S_ALU:                 state_d = (cnt >= ALU_LAST) ? S_WB : S_ALU;
            S_MOV, S_WB, S_BRANCH: state_d = S_FETCH;
            default:               state_d = S_IDLE;
        endcase
    end

    assign ir_ld  = state == S_FETCH;
    assign pc_inc = state == S_FETCH;
    assign mem_rd = state == S_LOAD;
    assign reg_we = (state == S_MOV) || (state == S_WB) || (state == S_LOAD && mem_ready);
    assign alu_en = state == S_ALU;
    assign pc_ld  = state == S_BRANCH;
    assign halted = state == S_HALT;
    assign err    = state == S_ERR;
endmodule
